// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the fetch stage (instruction reads) and the memory stage
// (data reads/writes) share one single-ported, variable-latency memory.
//
// Data requests win arbitration. The exception is when fetch is eligible and
// has already lost FAIR_LIMIT arbitrations in a row; then fetch is granted.
// Each access is one registered command: mem_en strobes for one cycle, while
// mem_addr, mem_wr and mem_wdata hold until the next grant. Completion returns
// the read data together with a one-cycle done pulse to the requester. If the
// memory never answers, a watchdog sets the sticky err flag and completes the
// access with zero data.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   if_req/if_addr       fetch read request (held until if_done)
//   if_rdata/if_done     fetch read data, valid with the one-cycle if_done
//   if_stall             if_req & ~if_done
//   d_req/d_wr/d_addr    data request (held until d_done), 1 = write
//   d_wdata              data write data
//   d_rdata/d_done       data read data (0 for writes), valid with d_done
//   d_stall              d_req & ~d_done
//   halt                 blocks new fetch grants
//   mem_en/mem_wr        one-cycle command strobe; write qualifier
//   mem_addr/mem_wdata   command address/data, held for the whole access
//   mem_rdata/mem_done   memory read data and completion pulse
//   err                  sticky watchdog error
module mem_arbiter #(
  parameter int unsigned FAIR_LIMIT = 3,
  parameter int unsigned TIMEOUT    = 64   // must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  input  logic        halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int unsigned FcW = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam logic [FcW-1:0] FairMax = FcW'(FAIR_LIMIT);
  // Count value during the last BUSY cycle allowed before the watchdog fires.
  localparam logic [WdW-1:0] WdLast  = WdW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StDoneI,
    StDoneD
  } state_e;

  state_e r_state, w_state_next;

  logic [FcW-1:0] r_fair;
  logic [WdW-1:0] r_wd;
  logic           r_mem_en;
  logic           r_mem_wr;
  logic [15:0]    r_mem_addr;
  logic [15:0]    r_mem_wdata;
  logic [15:0]    r_if_rdata;
  logic [15:0]    r_d_rdata;
  logic           r_err;

  logic w_idle;
  logic w_busy;
  logic w_fetch_elig;
  logic w_grant_d;
  logic w_grant_i;
  logic w_wd_expired;
  logic w_finish;

  // Arbitration and completion decode.
  always_comb begin
    w_idle       = (r_state == StIdle);
    w_busy       = (r_state == StBusyI) || (r_state == StBusyD);
    w_fetch_elig = if_req & ~halt;
    // Data wins unless fetch is eligible and has been passed over FAIR_LIMIT times.
    w_grant_d    = w_idle & d_req & (~w_fetch_elig | (r_fair < FairMax));
    w_grant_i    = w_idle & ~w_grant_d & w_fetch_elig;
    // A real mem_done in the last allowed cycle beats the watchdog.
    w_wd_expired = w_busy & ~mem_done & (r_wd == WdLast);
    w_finish     = w_busy & (mem_done | w_wd_expired);
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_state_next = StBusyD;
        end else if (w_grant_i) begin
          w_state_next = StBusyI;
        end
      end
      StBusyI: if (w_finish) w_state_next = StDoneI;
      StBusyD: if (w_finish) w_state_next = StDoneD;
      StDoneI: w_state_next = StIdle;
      StDoneD: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fairness counter: counts consecutive data grants that passed over an eligible fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fair <= '0;
    end else if (w_grant_i) begin
      r_fair <= '0;
    end else if (w_grant_d && w_fetch_elig && (r_fair != FairMax)) begin
      r_fair <= r_fair + FcW'(1);
    end
  end

  // Watchdog: cleared on entry to BUSY, counts each BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_wd <= '0;
    end else if (w_busy && !w_finish) begin
      r_wd <= r_wd + WdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_wd_expired) begin
      r_err <= 1'b1;
    end
  end

  // Memory command register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_grant_d | w_grant_i;
      if (w_grant_d) begin
        r_mem_wr    <= d_wr;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_mem_wr    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end
    end
  end

  // Read data capture; a watchdog completion or a data write returns zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_finish) begin
      if (r_state == StBusyI) begin
        r_if_rdata <= mem_done ? mem_rdata : 16'h0000;
      end else begin
        r_d_rdata <= (mem_done && !r_mem_wr) ? mem_rdata : 16'h0000;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign if_done   = (r_state == StDoneI);
  assign d_done    = (r_state == StDoneD);
  assign if_stall  = if_req & ~if_done;
  assign d_stall   = d_req & ~d_done;

endmodule
